// File: rtl/rob_pkg.sv
// Shared reorder-buffer types: result width, tag width and the writeback entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a. WORD_SIZE may be overridden with +define+WORD_SIZE=<n>.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package rob_pkg;
    localparam int WORD_SIZE   = `WORD_SIZE;
    localparam int ROB_ENTRIES = 10;
    localparam int TAG_W       = $clog2(ROB_ENTRIES);

    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic [WORD_SIZE-1:0] data;
        logic                 exc;
    } wb_entry_t;
endpackage

// File: rtl/rob_wb_arbiter_if.sv
// Completion bus: NUM_FU packed completion ports in, one writeback port out.
// Latency: n/a (wiring only).
// Backpressure: fu_ready per unit toward the FUs, wb_ready from the ROB.
// master = arbiter side (drives fu_ready and wb_*), slave = FUs plus ROB.
interface rob_wb_arbiter_if #(
    parameter int NUM_FU = 3
);
    import rob_pkg::*;

    logic [NUM_FU-1:0]           fu_valid;
    logic [NUM_FU-1:0]           fu_ready;
    logic [NUM_FU*TAG_W-1:0]     fu_tag;
    logic [NUM_FU*WORD_SIZE-1:0] fu_data;
    logic [NUM_FU-1:0]           fu_exc;
    logic                        wb_valid;
    logic                        wb_ready;
    logic [TAG_W-1:0]            wb_tag;
    logic [WORD_SIZE-1:0]        wb_data;
    logic                        wb_exc;

    modport master (
        input  fu_valid, fu_tag, fu_data, fu_exc, wb_ready,
        output fu_ready, wb_valid, wb_tag, wb_data, wb_exc
    );

    modport slave (
        output fu_valid, fu_tag, fu_data, fu_exc, wb_ready,
        input  fu_ready, wb_valid, wb_tag, wb_data, wb_exc
    );
endinterface

// File: rtl/wb_fifo.sv
// Circular per-FU completion FIFO holding wb_entry_t; depth need not be a power of 2.
// Latency: pushed entry is visible at head_ent the cycle after the push edge.
// Backpressure: full blocks pushes; flush empties it and wins over push/pop.
// Ports: clk, rst (async active-low), flush, push/push_ent, pop/head_ent, full, empty.
module wb_fifo
    import rob_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      push,
    input  wb_entry_t push_ent,
    input  logic      pop,
    output wb_entry_t head_ent,
    output logic      full,
    output logic      empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign head_ent = mem[rd_ptr];
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    // Storage needs no reset: only occupied slots are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_ent;
    end
endmodule

// File: rtl/rob_wb_arbiter.sv
// ROB completion front end: per-FU FIFOs, round-robin pick, one registered writeback/cycle.
// Latency: accept at edge k -> wb_valid from edge k+1 when uncontended.
// Backpressure: output register holds while wb_valid&!wb_ready; fu_ready = !fifo_full only.
// Ports: clk, rst (async active-low), flush, bus (master modport of rob_wb_arbiter_if).
// Optional macro WB_ARB_STATS_EN adds stat_wb_cnt / stat_stall_cnt counters.
module rob_wb_arbiter
    import rob_pkg::*;
#(
    parameter int NUM_FU     = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    rob_wb_arbiter_if.master       bus
`ifdef WB_ARB_STATS_EN
    ,
    output logic [31:0]            stat_wb_cnt,
    output logic [31:0]            stat_stall_cnt
`endif
);
    localparam int GNT_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    wb_entry_t         push_ent [NUM_FU];
    wb_entry_t         head_ent [NUM_FU];
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic [NUM_FU-1:0] full;
    logic [NUM_FU-1:0] empty;

    wb_entry_t         out_ent;
    logic              out_vld;
    logic [GNT_W-1:0]  last_grant;
    logic [GNT_W-1:0]  winner;
    logic              found;
    logic              load;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        assign push_ent[i] = '{tag:  bus.fu_tag[i*TAG_W +: TAG_W],
                               data: bus.fu_data[i*WORD_SIZE +: WORD_SIZE],
                               exc:  bus.fu_exc[i]};
        assign push[i] = bus.fu_valid[i] && !full[i];

        wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .push     (push[i]),
            .push_ent (push_ent[i]),
            .pop      (pop[i]),
            .head_ent (head_ent[i]),
            .full     (full[i]),
            .empty    (empty[i])
        );

        a_payload_stable: assert property (@(posedge clk) disable iff (!rst)
            (bus.fu_valid[i] && !bus.fu_ready[i]) |=> (bus.fu_valid[i] && $stable(push_ent[i])));
        a_tag_range: assert property (@(posedge clk) disable iff (!rst)
            push[i] |-> (int'(push_ent[i].tag) < ROB_ENTRIES));
    end

    // Ready comes from FIFO occupancy alone, so wb_ready never reaches fu_ready.
    assign bus.fu_ready = ~full;

    // Round-robin: first non-empty FIFO at or after last_grant+1, wrapping.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int j = 1; j <= NUM_FU; j++) begin
            idx = (int'(last_grant) + j) % NUM_FU;
            if (!found && !empty[idx]) begin
                found  = 1'b1;
                winner = GNT_W'(idx);
            end
        end
    end

    assign load = !out_vld || bus.wb_ready;

    always_comb begin
        pop = '0;
        if (!flush && load && found) pop[winner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld    <= 1'b0;
            out_ent    <= '0;
            last_grant <= GNT_W'(NUM_FU - 1);
        end else if (flush) begin
            out_vld <= 1'b0;
            out_ent <= '0;
        end else if (load) begin
            out_vld <= found;
            if (found) begin
                out_ent    <= head_ent[winner];
                last_grant <= winner;
            end
        end
    end

    assign bus.wb_valid = out_vld;
    assign bus.wb_tag   = out_ent.tag;
    assign bus.wb_data  = out_ent.data;
    assign bus.wb_exc   = out_ent.exc;

`ifdef WB_ARB_STATS_EN
    // Counters observe the raw handshake and deliberately ignore flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_wb_cnt    <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (out_vld && bus.wb_ready)  stat_wb_cnt    <= stat_wb_cnt + 32'd1;
            if (out_vld && !bus.wb_ready) stat_stall_cnt <= stat_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Self-checking bench for rob_wb_arbiter: queue-based reference model, directed cases, random traffic.
// Latency: n/a.
// Backpressure: random wb_ready and flush; FU sources hold payload until accepted.
module tb_rob_wb_arbiter;
    import rob_pkg::*;

    localparam int NUM_FU     = 3;
    localparam int FIFO_DEPTH = 2;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic flush = 1'b0;

    rob_wb_arbiter_if #(.NUM_FU(NUM_FU)) bus ();

`ifdef WB_ARB_STATS_EN
    logic [31:0] stat_wb_cnt;
    logic [31:0] stat_stall_cnt;
`endif

    rob_wb_arbiter #(.NUM_FU(NUM_FU), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
`ifdef WB_ARB_STATS_EN
        ,
        .stat_wb_cnt    (stat_wb_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: one queue per FU plus the single output slot.
    wb_entry_t   mq [NUM_FU][$];
    bit          m_vld;
    wb_entry_t   m_out;
    int          m_lg;
    int unsigned m_wb_cnt;
    int unsigned m_stall_cnt;
    int          mlog[$];
    bit          acc [NUM_FU];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int log_at(input int k);
        return (k >= 0 && k < mlog.size()) ? mlog[k] : -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_FU; i++) begin
            mq[i].delete();
            acc[i] = 1'b0;
        end
        m_vld       = 1'b0;
        m_out       = '0;
        m_lg        = NUM_FU - 1;
        m_wb_cnt    = 0;
        m_stall_cnt = 0;
        mlog.delete();
    endtask

    // Applies the rules for one rising edge using the inputs that were stable before it.
    task automatic model_edge();
        int w;
        bit rdy [NUM_FU];
        wb_entry_t e;
        for (int i = 0; i < NUM_FU; i++) begin
            rdy[i] = mq[i].size() < FIFO_DEPTH;
            acc[i] = bus.fu_valid[i] && rdy[i];
        end
        if (m_vld && bus.wb_ready)  m_wb_cnt++;
        if (m_vld && !bus.wb_ready) m_stall_cnt++;
        if (flush) begin
            for (int i = 0; i < NUM_FU; i++) mq[i].delete();
            m_vld = 1'b0;
            m_out = '0;
        end else begin
            if (!m_vld || bus.wb_ready) begin
                if (m_vld) mlog.push_back(int'(m_out.tag));
                w = -1;
                for (int j = 1; j <= NUM_FU; j++)
                    if (w < 0 && mq[(m_lg + j) % NUM_FU].size() > 0) w = (m_lg + j) % NUM_FU;
                if (w >= 0) begin
                    m_out = mq[w].pop_front();
                    m_vld = 1'b1;
                    m_lg  = w;
                end else begin
                    m_vld = 1'b0;
                end
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (acc[i]) begin
                    e.tag  = bus.fu_tag[i*TAG_W +: TAG_W];
                    e.data = bus.fu_data[i*WORD_SIZE +: WORD_SIZE];
                    e.exc  = bus.fu_exc[i];
                    mq[i].push_back(e);
                end
            end
        end
    endtask

    task automatic compare();
        logic [NUM_FU-1:0] mr;
        for (int i = 0; i < NUM_FU; i++) mr[i] = mq[i].size() < FIFO_DEPTH;
        chk("wb_valid", 64'(bus.wb_valid), 64'(m_vld));
        chk("fu_ready", 64'(bus.fu_ready), 64'(mr));
        if (m_vld) begin
            chk("wb_tag",  64'(bus.wb_tag),  64'(m_out.tag));
            chk("wb_data", 64'(bus.wb_data), 64'(m_out.data));
            chk("wb_exc",  64'(bus.wb_exc),  64'(m_out.exc));
        end
`ifdef WB_ARB_STATS_EN
        chk("stat_wb_cnt",    64'(stat_wb_cnt),    64'(m_wb_cnt));
        chk("stat_stall_cnt", 64'(stat_stall_cnt), 64'(m_stall_cnt));
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic set_fu(input int i, input bit v, input int tag, input logic [WORD_SIZE-1:0] data,
                          input bit exc);
        bus.fu_valid[i]                      = v;
        bus.fu_tag[i*TAG_W +: TAG_W]         = TAG_W'(tag);
        bus.fu_data[i*WORD_SIZE +: WORD_SIZE] = data;
        bus.fu_exc[i]                        = exc;
    endtask

    task automatic clear_fu();
        for (int i = 0; i < NUM_FU; i++) set_fu(i, 1'b0, 0, '0, 1'b0);
    endtask

    task automatic do_reset();
        clear_fu();
        flush = 1'b0;
        rst   = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        compare();
    endtask

    initial begin
        int pushed;
        int base;
        clear_fu();
        bus.wb_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Reset state
        chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("rst_fu_ready", 64'(bus.fu_ready), 64'b111);
        chk("rst_wb_tag",   64'(bus.wb_tag),   64'd0);
        chk("rst_wb_data",  64'(bus.wb_data),  64'd0);
        compare();
        for (int k = 0; k < 3; k++) cycle();

        // Asynchronous reset mid-cycle clears a valid output immediately
        set_fu(0, 1'b1, 9, 32'h1234_5678, 1'b1);
        cycle();
        clear_fu();
        cycle();
        chk("pre_async_wb_valid", 64'(bus.wb_valid), 64'd1);
        @(posedge clk);
        model_edge();
        #3 rst = 1'b0;
        #1;
        chk("async_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("async_wb_tag",   64'(bus.wb_tag),   64'd0);
        chk("async_wb_data",  64'(bus.wb_data),  64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        compare();

        // Single completion, two-edge latency
        bus.wb_ready = 1'b1;
        set_fu(1, 1'b1, 4, 32'hDEAD_BEEF, 1'b0);
        cycle();
        chk("single_not_yet", 64'(bus.wb_valid), 64'd0);
        clear_fu();
        cycle();
        chk("single_valid", 64'(bus.wb_valid), 64'd1);
        chk("single_tag",   64'(bus.wb_tag),   64'd4);
        chk("single_data",  64'(bus.wb_data),  64'hDEAD_BEEF);
        chk("single_exc",   64'(bus.wb_exc),   64'd0);
        cycle();
        chk("single_done", 64'(bus.wb_valid), 64'd0);

        // Round robin from reset pointer, then a second round
        do_reset();
        bus.wb_ready = 1'b1;
        for (int i = 0; i < NUM_FU; i++) set_fu(i, 1'b1, i + 1, WORD_SIZE'((i + 1) * 16), 1'b0);
        cycle();
        clear_fu();
        for (int k = 1; k <= 3; k++) begin
            cycle();
            chk("rr1_valid", 64'(bus.wb_valid), 64'd1);
            chk("rr1_tag",   64'(bus.wb_tag),   64'(k));
        end
        set_fu(0, 1'b1, 5, 32'h55, 1'b0);
        set_fu(2, 1'b1, 6, 32'h66, 1'b1);
        cycle();
        clear_fu();
        chk("rr2_tag0", 64'(bus.wb_tag), 64'd3);
        cycle();
        chk("rr2_tag1", 64'(bus.wb_tag), 64'd5);
        cycle();
        chk("rr2_tag2", 64'(bus.wb_tag), 64'd6);
        chk("rr2_exc2", 64'(bus.wb_exc), 64'd1);
        cycle();
        chk("rr2_idle", 64'(bus.wb_valid), 64'd0);

        // Backpressure: five stalled cycles while FU0 offers three entries
        do_reset();
        bus.wb_ready = 1'b0;
        pushed = 0;
        for (int k = 0; k < 5; k++) begin
            if (pushed < 3) set_fu(0, 1'b1, 7 + pushed, WORD_SIZE'(32'hA0 + pushed), 1'b0);
            else clear_fu();
            cycle();
            if (pushed < 3 && acc[0]) pushed++;
            if (k >= 2) begin
                chk("bp_hold_valid", 64'(bus.wb_valid), 64'd1);
                chk("bp_hold_tag",   64'(bus.wb_tag),   64'd7);
                chk("bp_ready0_low", 64'(bus.fu_ready[0]), 64'd0);
            end
        end
        chk("bp_pushed", 64'(pushed), 64'd3);
        clear_fu();
        bus.wb_ready = 1'b1;
        base = mlog.size();
        for (int k = 0; k < 4; k++) cycle();
        chk("bp_order0", 64'(log_at(base)),     64'd7);
        chk("bp_order1", 64'(log_at(base + 1)), 64'd8);
        chk("bp_order2", 64'(log_at(base + 2)), 64'd9);

        // Flush with a valid output, two buffered entries and a simultaneous FU2 push
        do_reset();
        bus.wb_ready = 1'b0;
        set_fu(0, 1'b1, 1, 32'h11, 1'b0);
        set_fu(1, 1'b1, 3, 32'h33, 1'b0);
        cycle();
        set_fu(0, 1'b1, 2, 32'h22, 1'b0);
        set_fu(1, 1'b0, 0, '0, 1'b0);
        cycle();
        chk("fl_pre_valid", 64'(bus.wb_valid), 64'd1);
        clear_fu();
        set_fu(2, 1'b1, 5, 32'h77, 1'b0);
        flush        = 1'b1;
        bus.wb_ready = 1'b1;
        cycle();
        flush = 1'b0;
        clear_fu();
        chk("fl_valid", 64'(bus.wb_valid), 64'd0);
        chk("fl_ready", 64'(bus.fu_ready), 64'b111);
        base = mlog.size();
        for (int k = 0; k < 4; k++) cycle();
        chk("fl_no_wb", 64'(bus.wb_valid), 64'd0);
        chk("fl_log",   64'(mlog.size() - base), 64'd0);

`ifdef WB_ARB_STATS_EN
        // Counters: 3 stalls then 4 writebacks, untouched by flush
        do_reset();
        bus.wb_ready = 1'b0;
        set_fu(0, 1'b1, 1, 32'h1, 1'b0);
        set_fu(1, 1'b1, 2, 32'h2, 1'b0);
        cycle();
        set_fu(0, 1'b1, 3, 32'h3, 1'b0);
        set_fu(1, 1'b1, 4, 32'h4, 1'b0);
        cycle();
        clear_fu();
        for (int k = 0; k < 3; k++) cycle();
        bus.wb_ready = 1'b1;
        for (int k = 0; k < 5; k++) cycle();
        chk("st_wb",    64'(stat_wb_cnt),    64'd4);
        chk("st_stall", 64'(stat_stall_cnt), 64'd3);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("st_wb_fl",    64'(stat_wb_cnt),    64'd4);
        chk("st_stall_fl", 64'(stat_stall_cnt), 64'd3);
`endif

        // Random traffic with hold-until-accepted sources
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (!(bus.fu_valid[i] && !acc[i]))
                    set_fu(i, $urandom_range(0, 2) == 0, $urandom_range(0, ROB_ENTRIES - 1),
                           WORD_SIZE'($urandom), $urandom_range(0, 1) == 1);
            end
            bus.wb_ready = $urandom_range(0, 3) != 0;
            flush        = $urandom_range(0, 40) == 0;
            cycle();
        end
        clear_fu();
        flush        = 1'b0;
        bus.wb_ready = 1'b1;
        for (int k = 0; k < 12; k++) cycle();
        chk("drain_idle", 64'(bus.wb_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
